signed_divider_module: RTL and testbench

Sequential signed 16÷8 divider. It is the inverse companion of the LUT multiplier: it recovers an 8-bit factor from a 16-bit signed product and the other 8-bit factor. It uses the same start_sig/done_sig handshake as the multiplier, so a single controller can drive either block. The algorithm is restoring shift-subtract on magnitudes, followed by a sign fix-up.

---
 rtl/signed_divider_module.sv | 120 ++++++++++++
 tb/tb_signed_divider_module.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/signed_divider_module.sv
// rtl/signed_divider_module.sv - sequential signed 16/8 restoring divider with start/done handshake
module signed_divider_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_sig,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        done_sig,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        div_zero,
    output logic        overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]  r_state;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [15:0] r_dvd;
    logic [7:0]  r_dvs;
    logic [7:0]  r_prem;
    logic [3:0]  r_cnt;

    logic [15:0] w_dvd_mag;
    logic [7:0]  w_dvs_mag;
    logic [8:0]  w_shift;
    logic        w_ge;
    logic [7:0]  w_prem_next;
    logic        w_ov;
    logic [7:0]  w_q_signed;
    logic [7:0]  w_r_signed;

    assign w_dvd_mag = dividend[15] ? (~dividend + 16'd1) : dividend;
    assign w_dvs_mag = divisor[7] ? (~divisor + 8'd1) : divisor;

    // The partial remainder stays below |divisor| <= 128, so the post-subtract value fits in 8 bits.
    assign w_shift     = {r_prem, r_dvd[15]};
    assign w_ge        = (w_shift >= {1'b0, r_dvs});
    assign w_prem_next = w_ge ? (w_shift[7:0] - r_dvs) : w_shift[7:0];

    // A negative quotient may reach magnitude 128 (-128) without overflowing.
    assign w_ov       = r_neg_q ? (r_dvd > 16'd128) : (r_dvd > 16'd127);
    assign w_q_signed = r_neg_q ? (~r_dvd[7:0] + 8'd1) : r_dvd[7:0];
    assign w_r_signed = r_neg_r ? (~r_prem + 8'd1) : r_prem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_dvd     <= 16'd0;
            r_dvs     <= 8'd0;
            r_prem    <= 8'd0;
            r_cnt     <= 4'd0;
            done_sig  <= 1'b0;
            quotient  <= 8'd0;
            remainder <= 8'd0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_sig) begin
                        r_neg_q <= dividend[15] ^ divisor[7];
                        r_neg_r <= dividend[15];
                        r_dvs   <= w_dvs_mag;
                        r_prem  <= 8'd0;
                        r_cnt   <= 4'd0;
                        // On divide-by-zero the raw dividend is kept so its low byte becomes the remainder.
                        if (divisor == 8'd0) begin
                            r_dz    <= 1'b1;
                            r_dvd   <= dividend;
                            r_state <= S_FIX;
                        end else begin
                            r_dz    <= 1'b0;
                            r_dvd   <= w_dvd_mag;
                            r_state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_prem <= w_prem_next;
                    r_dvd  <= {r_dvd[14:0], w_ge};
                    r_cnt  <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_dz) begin
                        quotient  <= 8'h00;
                        remainder <= r_dvd[7:0];
                        div_zero  <= 1'b1;
                        overflow  <= 1'b0;
                    end else begin
                        quotient  <= w_ov ? (r_neg_q ? 8'h80 : 8'h7F) : w_q_signed;
                        remainder <= w_r_signed;
                        div_zero  <= 1'b0;
                        overflow  <= w_ov;
                    end
                    done_sig <= 1'b1;
                    r_state  <= S_WAIT;
                end
                default: begin
                    done_sig <= 1'b0;
                    if (!start_sig) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_module.sv
// tb/tb_signed_divider_module.sv - table-driven scoreboard bench for signed_divider_module
module tb_signed_divider_module;

    logic        clk;
    logic        rst;
    logic        start_sig;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        done_sig;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        overflow;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[13];
    vec_t sb[$];

    signed_divider_module dut (
        .clk(clk),
        .rst(rst),
        .start_sig(start_sig),
        .dividend(dividend),
        .divisor(divisor),
        .done_sig(done_sig),
        .quotient(quotient),
        .remainder(remainder),
        .div_zero(div_zero),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] dvd, input logic [7:0] dvs, input logic [7:0] q,
                                input logic [7:0] r, input logic dz, input logic ov, input int lat,
                                input int hold);
        vec_t v;
        v.dvd = dvd; v.dvs = dvs; v.q = q; v.r = r; v.dz = dz; v.ov = ov; v.lat = lat; v.hold = hold;
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        vec_t e;
        int cyc;
        bit seen;
        @(negedge clk);
        dividend  = v.dvd;
        divisor   = v.dvs;
        start_sig = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        // Inputs must be ignored after the capture edge.
        @(negedge clk);
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            if (cyc > 0) @(posedge clk);
            else @(posedge clk);
            #1;
            cyc++;
            if (done_sig) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
        check("latency", cyc, v.lat);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("quotient", int'(quotient), int'(e.q));
            check("remainder", int'(remainder), int'(e.r));
            check("div_zero", int'(div_zero), int'(e.dz));
            check("overflow", int'(overflow), int'(e.ov));
        end
        // Holding start must not retrigger; done stays one cycle wide.
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            check("no_retrigger", int'(done_sig), 0);
        end
        @(negedge clk);
        start_sig = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start_sig = 1'b1;
        dividend  = 16'd510;
        divisor   = 8'd34;

        vecs[0]  = mk(16'd510,  8'd34,  8'd15,  8'd0,   1'b0, 1'b0, 17, 1);
        vecs[1]  = mk(16'hFB64, 8'd59,  8'hEC,  8'd0,   1'b0, 1'b0, 17, 1);
        vecs[2]  = mk(16'hC0FF, 8'd127, 8'h81,  8'd0,   1'b0, 1'b0, 17, 1);
        vecs[3]  = mk(16'hFFF9, 8'd2,   8'hFD,  8'hFF,  1'b0, 1'b0, 17, 1);
        vecs[4]  = mk(16'd7,    8'hFE,  8'hFD,  8'h01,  1'b0, 1'b0, 17, 1);
        vecs[5]  = mk(16'd1000, 8'd3,   8'h7F,  8'h01,  1'b0, 1'b1, 17, 1);
        vecs[6]  = mk(16'h8000, 8'hFF,  8'h7F,  8'h00,  1'b0, 1'b1, 17, 1);
        vecs[7]  = mk(16'hFF00, 8'd2,   8'h80,  8'h00,  1'b0, 1'b0, 17, 1);
        vecs[8]  = mk(16'd256,  8'd2,   8'h7F,  8'h00,  1'b0, 1'b1, 17, 1);
        vecs[9]  = mk(16'hFEFF, 8'd2,   8'h80,  8'hFF,  1'b0, 1'b0, 17, 1);
        vecs[10] = mk(16'd1000, 8'h80,  8'hF9,  8'h68,  1'b0, 1'b0, 17, 1);
        vecs[11] = mk(16'd1234, 8'd0,   8'h00,  8'hD2,  1'b1, 1'b0, 1,  10);
        vecs[12] = mk(16'hFF81, 8'h81,  8'h01,  8'h00,  1'b0, 1'b0, 17, 1);

        // Start asserted while in reset must be ignored.
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", int'(done_sig), 0);
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_flags", int'({div_zero, overflow}), 0);
        @(negedge clk);
        start_sig = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i]);
        end

        // Abort in the middle of ITER: outputs clear, no done, then a clean operation follows.
        @(negedge clk);
        dividend  = 16'd510;
        divisor   = 8'd34;
        start_sig = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        start_sig = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done", int'(done_sig), 0);
        check("abort_q", int'(quotient), 0);
        check("abort_r", int'(remainder), 0);
        check("abort_dz", int'(div_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", int'(done_sig), 0);
        end
        run_op(vecs[0]);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
